// File: rtl/decode_seq.sv
// Instruction sequencer for a single-issue core: fetch, decode, issue and
// wait for writeback of one instruction at a time. Stops on ebreak or on an illegal opcode.
module decode_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_valid,
    input  logic [31:0] ifu_inst,
    output logic        ifu_ready,
    output logic [31:0] inst_q,
    output logic        is_csr,
    output logic        exu_valid,
    input  logic        exu_ready,
    input  logic        wb_done,
    input  logic        flush,
    output logic [31:0] retired,
    output logic        halted,
    output logic        halt_code
);

    localparam logic [31:0] EBREAK_INST = 32'h00100073;
    localparam logic [6:0]  OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {FETCH, DECODE, ISSUE, WAIT_WB, HALT} state_t;

    state_t state;
    state_t state_next;
    logic   fetch_accept;
    logic   retire;
    logic   halt_enter;
    logic   halt_illegal;

    function automatic logic opcode_legal(input logic [6:0] op);
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011:
                opcode_legal = 1'b1;
            default:
                opcode_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // flush outranks every handshake input in all non-halted states
    always_comb begin
        state_next   = state;
        fetch_accept = 1'b0;
        retire       = 1'b0;
        halt_enter   = 1'b0;
        halt_illegal = 1'b0;
        case (state)
            FETCH: begin
                if (flush) begin
                    state_next = FETCH;
                end else if (ifu_valid) begin
                    fetch_accept = 1'b1;
                    state_next   = DECODE;
                end
            end
            DECODE: begin
                if (flush) begin
                    state_next = FETCH;
                end else if (inst_q == EBREAK_INST) begin
                    halt_enter = 1'b1;
                    state_next = HALT;
                end else if (!opcode_legal(inst_q[6:0])) begin
                    halt_enter   = 1'b1;
                    halt_illegal = 1'b1;
                    state_next   = HALT;
                end else begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (flush) begin
                    state_next = FETCH;
                end else if (exu_ready) begin
                    state_next = WAIT_WB;
                end
            end
            WAIT_WB: begin
                if (flush) begin
                    state_next = FETCH;
                end else if (wb_done) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q    <= 32'd0;
            retired   <= 32'd0;
            halt_code <= 1'b0;
        end else begin
            if (fetch_accept) begin
                inst_q <= ifu_inst;
            end
            if (retire) begin
                retired <= retired + 32'd1;
            end
            if (halt_enter) begin
                halt_code <= halt_illegal;
            end
        end
    end

    assign ifu_ready = (state == FETCH);
    assign exu_valid = (state == ISSUE);
    assign halted    = (state == HALT);
    assign is_csr    = (inst_q[6:0] == OP_SYSTEM);

endmodule

// File: doc/decode_seq.md
DECODE_SEQ -- requirements
Module: decode_seq

Interface
REQ-001 SHALL have parameter RST_PC_UNUSED: none; the block has no parameters.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_valid  in  1  fetch unit presents an instruction.
- ifu_inst  in  32  fetched instruction word.
- ifu_ready  out  1  sequencer accepts an instruction this cycle.
- inst_q  out  32  latched instruction driving the decoder input.
- is_csr  out  1  inst_q[6:0]==7'b1110011; drives decoder rs2 suppression.
- exu_valid  out  1  decoded instruction offered to execute.
- exu_ready  in  1  execute accepts the instruction.
- wb_done  in  1  execute/writeback of the issued instruction complete.
- flush  in  1  redirect; abandon the current instruction.
- retired  out  32  count of completed instructions.
- halted  out  1  sequencer stopped.
- halt_code  out  1  0 = ebreak, 1 = illegal opcode.

Function
REQ-003 SHALL implement FSM states FETCH, DECODE, ISSUE, WAIT_WB, HALT; all outputs Moore except is_csr, which is combinational from inst_q.
REQ-004 FETCH: ifu_ready=1; on ifu_valid, SHALL latch ifu_inst into inst_q and move to DECODE next cycle; otherwise stay.
REQ-005 DECODE: exactly one cycle; SHALL classify inst_q[6:0].
- Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 1110011.
- If inst_q==32'h00100073 (ebreak): next state HALT, halt_code=0.
- Else if opcode illegal: next state HALT, halt_code=1.
- Else: next state ISSUE.
REQ-006 ISSUE: exu_valid=1, held with inst_q stable until exu_ready; on exu_ready SHALL move to WAIT_WB.
REQ-007 WAIT_WB: on wb_done SHALL increment retired by 1 and return to FETCH.
REQ-008 Minimum instruction period SHALL be 4 cycles (FETCH, DECODE, ISSUE, WAIT_WB) with ifu_valid, exu_ready and wb_done all immediately asserted.
REQ-009 HALT: halted=1; ifu_ready=0 and exu_valid=0; SHALL remain in HALT until rst, ignoring flush, ifu_valid and wb_done.
REQ-010 flush in FETCH, DECODE, ISSUE or WAIT_WB SHALL force FETCH next cycle with no retire increment and no halt.
- Priority: flush over ifu_valid, exu_ready and wb_done in the same cycle.
- flush in FETCH together with ifu_valid SHALL NOT latch the instruction.
REQ-011 inst_q SHALL change only on an accepted fetch (FETCH and ifu_valid and not flush).
REQ-012 wb_done outside WAIT_WB and exu_ready outside ISSUE SHALL be ignored.
REQ-013 retired SHALL wrap from 32'hFFFFFFFF to 0 without side effects.
REQ-014 ifu_ready and exu_valid SHALL never be 1 in the same cycle.

Reset
REQ-015 rst=1 at a clock edge SHALL, from any state including HALT or mid-handshake:
- enter FETCH;
- clear inst_q to 0, retired to 0, halted to 0 and halt_code to 0;
- drive exu_valid=0.
REQ-016 ifu_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-017 rst SHALL take priority over every other input.

Verification
REQ-018 Back-to-back addi (32'h00100093) with ifu_valid, exu_ready and wb_done held at 1: required response is ifu_ready high every 4th cycle, exu_valid high 1 of every 4 cycles, and retired=3 after 12 cycles.
REQ-019 exu_ready held low 5 cycles in ISSUE: required response is exu_valid held high and inst_q unchanged for those 5 cycles, then WAIT_WB on the cycle after exu_ready=1.
REQ-020 Fetch 32'h00100073: required response is halted=1 and halt_code=0 two cycles after the fetch; a later ifu_valid is not accepted and retired is unchanged.
REQ-021 Fetch 32'hFFFFFFFF (illegal opcode): required response is halted=1 and halt_code=1; rst=1 then clears halted, returns to FETCH and sets retired=0.
REQ-022 flush asserted in WAIT_WB together with wb_done: required response is FETCH next cycle with retired not incremented; flush with ifu_valid in FETCH leaves inst_q unchanged.
REQ-023 csrrw 32'h34011073 in DECODE: required response is is_csr=1; with retired preloaded to 32'hFFFFFFFF (via 2^32 retirements or a forced value), one more retirement gives retired=0.
